// File: rtl/sram_pkg.sv
// Shared types and constants for the sequenced SRAM bank.
package sram_pkg;

    localparam int unsigned ByteW = 8;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StPre,
        StWl,
        StSense
    } state_e;

    typedef struct packed {
        logic pre_en;
        logic write_en;
        logic sense_en;
    } phase_t;

endpackage

// File: rtl/sram_row_decoder.sv
// Address to one-hot wordline decoder; rows beyond ROWS-1 decode to all-zero.
module sram_row_decoder #(
    parameter int unsigned ROWS   = 64,
    parameter int unsigned ADDR_W = $clog2(ROWS)
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
    output logic [ROWS-1:0]   wl_o
);

    // Compare against every valid row so out-of-range codes match nothing
    always_comb begin
        wl_o = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (en_i && (addr_i == ADDR_W'(r))) begin
                wl_o[r] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_bank_seq.sv
// SRAM bank with a clocked precharge / wordline / write-or-sense sequencer,
// byte-enabled writes and an optional zeroing sweep after reset.
module sram_bank_seq
    import sram_pkg::*;
#(
    parameter int unsigned ROWS          = 64,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned ADDR_W        = $clog2(ROWS),
    parameter int unsigned BE_W          = DATA_W / ByteW,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [ROWS-1:0]   wl_o,
    output logic              pre_en_o,
    output logic              write_en_o,
    output logic              sense_en_o,
    output logic              busy_o
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   row_cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q [ROWS];

    phase_t              phase;
    logic                wl_en;
    logic [ADDR_W-1:0]   dec_addr;
    logic                in_range;
    logic                accept;

    assign accept   = req_valid_i && (state_q == StIdle);
    assign in_range = (32'(addr_q) < ROWS);

    // State register with synchronous reset into the sweep or straight to idle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= INIT_ON_RESET ? StInit : StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (row_cnt_q == ADDR_W'(ROWS - 1)) state_d = StIdle;
            StIdle:  if (req_valid_i) state_d = StPre;
            StPre:   state_d = StWl;
            StWl:    state_d = we_q ? StIdle : StSense;
            StSense: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Phase strobes; forced quiet while reset is held so nothing drives the array
    always_comb begin
        phase    = '0;
        wl_en    = 1'b0;
        dec_addr = addr_q;
        unique case (state_q)
            StInit: begin
                wl_en          = 1'b1;
                phase.write_en = 1'b1;
                dec_addr       = row_cnt_q;
            end
            StPre: phase.pre_en = 1'b1;
            StWl: begin
                wl_en          = 1'b1;
                phase.write_en = we_q;
            end
            StSense: begin
                wl_en          = 1'b1;
                phase.sense_en = 1'b1;
            end
            default: ;
        endcase
        if (rst_i) begin
            phase = '0;
            wl_en = 1'b0;
        end
    end

    sram_row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .addr_i (dec_addr),
        .en_i   (wl_en),
        .wl_o   (wl_o)
    );

    assign pre_en_o    = phase.pre_en;
    assign write_en_o  = phase.write_en;
    assign sense_en_o  = phase.sense_en;
    assign busy_o      = (state_q != StIdle);
    assign req_ready_o = (state_q == StIdle);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;

    // Sweep row counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_cnt_q <= '0;
        end else if (state_q == StInit) begin
            row_cnt_q <= row_cnt_q + ADDR_W'(1);
        end
    end

    // Request capture at the accepting edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            addr_q  <= req_addr_i;
            we_q    <= req_we_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
        end
    end

    // Read capture at the end of SENSE; response pulses in the following idle cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= (state_q == StSense);
            if (state_q == StSense) begin
                rdata_q <= in_range ? mem_q[addr_q] : '0;
            end
        end
    end

    // Array writes: sweep zeroing or byte-enabled commit at the end of WL
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == StInit) begin
                mem_q[row_cnt_q] <= '0;
            end else if ((state_q == StWl) && we_q && in_range) begin
                for (int unsigned b = 0; b < BE_W; b++) begin
                    if (be_q[b]) begin
                        mem_q[addr_q][b*ByteW +: ByteW] <= wdata_q[b*ByteW +: ByteW];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_bank_seq.sv
// Self-checking bench: a 64-row bank with the reset sweep and a 48-row bank without it,
// sharing one request bus selected by sel.
module tb_sram_bank_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        valid, we;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          sel;

    logic        a_ready, a_rsp_valid, a_pre, a_wen, a_sen, a_busy;
    logic [31:0] a_rdata;
    logic [63:0] a_wl;
    logic        b_ready, b_rsp_valid, b_pre, b_wen, b_sen, b_busy;
    logic [31:0] b_rdata;
    logic [47:0] b_wl;

    logic        o_ready, o_rsp_valid, o_pre, o_wen, o_sen, o_busy;
    logic [31:0] o_rdata;
    logic [63:0] o_wl;
    logic [69:0] obs_s;

    int nvec  = 0;
    int nfail = 0;

    logic [31:0] mdl [2][64];

    sram_bank_seq #(.ROWS(64), .DATA_W(32), .INIT_ON_RESET(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .req_valid_i(valid && !sel), .req_ready_o(a_ready),
        .req_we_i(we), .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
        .rsp_valid_o(a_rsp_valid), .rsp_rdata_o(a_rdata), .wl_o(a_wl), .pre_en_o(a_pre),
        .write_en_o(a_wen), .sense_en_o(a_sen), .busy_o(a_busy)
    );

    sram_bank_seq #(.ROWS(48), .DATA_W(32), .INIT_ON_RESET(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .req_valid_i(valid && sel), .req_ready_o(b_ready),
        .req_we_i(we), .req_addr_i(addr), .req_wdata_i(wdata), .req_be_i(be),
        .rsp_valid_o(b_rsp_valid), .rsp_rdata_o(b_rdata), .wl_o(b_wl), .pre_en_o(b_pre),
        .write_en_o(b_wen), .sense_en_o(b_sen), .busy_o(b_busy)
    );

    assign o_ready     = sel ? b_ready : a_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_pre       = sel ? b_pre : a_pre;
    assign o_wen       = sel ? b_wen : a_wen;
    assign o_sen       = sel ? b_sen : a_sen;
    assign o_busy      = sel ? b_busy : a_busy;
    assign o_rdata     = sel ? b_rdata : a_rdata;
    assign o_wl        = sel ? {16'b0, b_wl} : a_wl;
    assign obs_s       = {o_pre, o_wen, o_sen, o_ready, o_busy, o_rsp_valid, o_wl};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [69:0] sv(input bit pre, input bit wen, input bit sen,
                                       input bit rdy, input bit bsy, input bit rv,
                                       input logic [63:0] wl);
        return {pre, wen, sen, rdy, bsy, rv, wl};
    endfunction

    function automatic logic [63:0] onehot(input int a, input int rows);
        return (a < rows) ? (64'd1 << a) : 64'd0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] e);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (e[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic set_sel(input bit s);
        sel = s;
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        @(negedge clk);
        while (!o_ready && k < 200) begin
            k++;
            @(negedge clk);
        end
        chk(tag, o_ready, 1'b1);
    endtask

    // One request through the full phase sequence, checking every cycle
    task automatic txn(input bit w, input int a, input logic [31:0] d, input logic [3:0] e,
                       input bit chained, input bit keep, input int na, input bit poke);
        int rows = sel ? 48 : 64;
        logic [63:0] ewl = onehot(a, rows);
        logic [31:0] exp_rd;
        if (!chained) begin
            @(posedge clk); #1;
            valid = 1'b1; we = w; addr = 6'(a); wdata = d; be = e;
            wait_ready("ready");
        end
        @(posedge clk); #1;
        if (keep) addr = 6'(na);
        else valid = 1'b0;
        exp_rd = (a < rows) ? mdl[sel][a] : 32'd0;
        @(negedge clk); chk("pre", obs_s, sv(1, 0, 0, 0, 1, 0, 64'd0));
        if (poke) begin
            @(posedge clk); #1;
            valid = 1'b1; we = 1'b1; addr = 6'(a); wdata = ~d; be = 4'hF;
        end
        @(negedge clk); chk("wl", obs_s, sv(0, w, 0, 0, 1, 0, ewl));
        if (poke) begin
            @(posedge clk); #1;
            valid = 1'b0;
        end
        if (w) begin
            if (a < rows) mdl[sel][a] = merge(mdl[sel][a], d, e);
            @(negedge clk); chk("wdone", obs_s, sv(0, 0, 0, 1, 0, 0, 64'd0));
        end else begin
            @(negedge clk); chk("sense", obs_s, sv(0, 0, 1, 0, 1, 0, ewl));
            @(negedge clk); chk("rsp", obs_s, sv(0, 0, 0, 1, 0, 1, 64'd0));
            chk("rdata", o_rdata, exp_rd);
            if (!keep) begin
                @(negedge clk); chk("rsp_pulse", {o_rsp_valid, o_rdata}, {1'b0, exp_rd});
            end
        end
    endtask

    // Accept a request, then hold reset during cycle T+k of its sequence
    task automatic abort_txn(input bit w, input int a, input logic [31:0] d,
                             input logic [3:0] e, input int k);
        @(posedge clk); #1;
        valid = 1'b1; we = w; addr = 6'(a); wdata = d; be = e;
        wait_ready("ab_ready");
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (k - 1) @(posedge clk);
        #1;
        if (sel) rst_b = 1'b1;
        else rst_a = 1'b1;
        @(negedge clk); chk("ab_quiet", {o_pre, o_wen, o_sen, o_rsp_valid, o_wl}, 68'd0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        if (!sel) for (int i = 0; i < 64; i++) mdl[0][i] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("ab_norsp", o_rsp_valid, 1'b0);
        end
        wait_ready("ab_reinit");
    endtask

    // Strobe invariants on both banks every cycle
    always @(negedge clk) begin
        if (!rst_a) begin
            nvec++;
            assert (!(a_pre && a_wl != 0) && !(a_wen && a_sen) && $onehot0(a_wl)) else begin
                nfail++;
                $error("FAIL inv_a: observed pre=%b wen=%b sen=%b wl=%h expected exclusive",
                       a_pre, a_wen, a_sen, a_wl);
            end
        end
        if (!rst_b) begin
            nvec++;
            assert (!(b_pre && b_wl != 0) && !(b_wen && b_sen) && $onehot0(b_wl)) else begin
                nfail++;
                $error("FAIL inv_b: observed pre=%b wen=%b sen=%b wl=%h expected exclusive",
                       b_pre, b_wen, b_sen, b_wl);
            end
        end
    end

    initial begin
        valid = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
        rst_a = 1'b1; rst_b = 1'b1;
        set_sel(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a", {obs_s, o_rdata}, {sv(0, 0, 0, 0, 1, 0, 64'd0), 32'd0});
        set_sel(1);
        chk("rst_b", {obs_s, o_rdata}, {sv(0, 0, 0, 1, 0, 0, 64'd0), 32'd0});
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        set_sel(0);

        // Zeroing sweep walks every wordline with write_en, then ready
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); chk("init_walk", obs_s, sv(0, 1, 0, 0, 1, 0, 64'd1 << i));
        end
        @(negedge clk); chk("init_done", obs_s, sv(0, 0, 0, 1, 0, 0, 64'd0));
        for (int i = 0; i < 64; i++) mdl[0][i] = 32'd0;

        txn(0, 17, 0, 0, 0, 0, 0, 0);
        txn(1, 5, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0);
        txn(1, 5, 32'h00AA0000, 4'b0100, 0, 0, 0, 0);
        txn(0, 5, 0, 0, 0, 0, 0, 0);
        chk("byte_merge", mdl[0][5], 32'hDEAABEEF);
        txn(1, 6, 32'h01020304, 4'b0000, 0, 0, 0, 0);
        txn(0, 6, 0, 0, 0, 0, 0, 0);

        // Back-to-back reads with valid held high
        txn(1, 0, $urandom, 4'hF, 0, 0, 0, 0);
        txn(1, 63, $urandom, 4'hF, 0, 0, 0, 0);
        txn(1, 1, $urandom, 4'hF, 0, 0, 0, 0);
        txn(0, 0, 0, 0, 0, 1, 63, 0);
        txn(0, 63, 0, 0, 1, 1, 1, 0);
        txn(0, 1, 0, 0, 1, 0, 0, 0);

        // Request pulsed while busy is ignored
        txn(0, 5, 32'h5A5A5A5A, 0, 0, 0, 0, 1);
        txn(0, 5, 0, 0, 0, 0, 0, 0);

        // Reset during a write's WL and a read's SENSE, with the sweep
        txn(1, 9, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
        abort_txn(1, 9, 32'h12345678, 4'hF, 2);
        txn(0, 9, 0, 0, 0, 0, 0, 0);
        abort_txn(0, 9, 0, 0, 3);

        // No-sweep bank: reset does not clear, out-of-range is inert
        set_sel(1);
        txn(1, 9, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
        abort_txn(1, 9, 32'h12345678, 4'hF, 2);
        txn(0, 9, 0, 0, 0, 0, 0, 0);
        txn(1, 0, 32'h11111111, 4'hF, 0, 0, 0, 0);
        txn(1, 47, 32'h47474747, 4'hF, 0, 0, 0, 0);
        txn(1, 50, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0);
        txn(0, 50, 0, 0, 0, 0, 0, 0);
        txn(0, 0, 0, 0, 0, 0, 0, 0);
        txn(0, 47, 0, 0, 0, 0, 0, 0);

        // Random traffic on the swept bank
        set_sel(0);
        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), $urandom,
                4'($urandom_range(0, 15)), 0, 0, 0, 0);
        end
        for (int i = 0; i < 64; i += 7) txn(0, i, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
